// File: rtl/sys2x2_pkg.sv
// ---------------------------------------------------------------------------
// sys2x2_pkg
// Shared types and constants for the 2x2 systolic array sequencer.
//   state_t            : sequencer FSM states
//   FEED_STEPS         : number of skewed feed cycles
//   E00/E01/E10/E11    : element slice indices into a flattened 2x2 matrix
//                        {x11,x10,x01,x00}, x00 in the LSBs
// ---------------------------------------------------------------------------
package sys2x2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int FEED_STEPS = 3;

   localparam int E00 = 0;
   localparam int E01 = 1;
   localparam int E10 = 2;
   localparam int E11 = 3;

   // Width of a down-counter that must hold n-1 down to 0.
   function automatic int drain_cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sys2x2_feed_mux.sv
// ---------------------------------------------------------------------------
// sys2x2_feed_mux
// Combinational step -> array edge value selection for the skewed feed.
// Ports:
//   step      in  2      feed step index (0..2; any other value gives zeros)
//   a_op      in  4*DW   latched A {a11,a10,a01,a00}
//   b_op      in  4*DW   latched B {b11,b10,b01,b00}
//   row0/row1 out DW     A values for the row-0 / row-1 edges
//   col0/col1 out DW     B values for the col-0 / col-1 edges
// ---------------------------------------------------------------------------
module sys2x2_feed_mux
   import sys2x2_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]      step,
   input  logic [4*DW-1:0] a_op,
   input  logic [4*DW-1:0] b_op,
   output logic [DW-1:0]   row0,
   output logic [DW-1:0]   row1,
   output logic [DW-1:0]   col0,
   output logic [DW-1:0]   col1
);

   logic [DW-1:0] a00, a01, a10, a11;
   logic [DW-1:0] b00, b01, b10, b11;

   assign a00 = a_op[E00*DW +: DW];
   assign a01 = a_op[E01*DW +: DW];
   assign a10 = a_op[E10*DW +: DW];
   assign a11 = a_op[E11*DW +: DW];
   assign b00 = b_op[E00*DW +: DW];
   assign b01 = b_op[E01*DW +: DW];
   assign b10 = b_op[E10*DW +: DW];
   assign b11 = b_op[E11*DW +: DW];

   // Row 1 and column 1 lag by one step so each PE sees matching k indices.
   always_comb begin
      row0 = '0;
      row1 = '0;
      col0 = '0;
      col1 = '0;
      case (step)
         2'd0: begin
            row0 = a00;
            col0 = b00;
         end
         2'd1: begin
            row0 = a01;
            row1 = a10;
            col0 = b10;
            col1 = b01;
         end
         2'd2: begin
            row1 = a11;
            col1 = b11;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/systolic_2x2_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_2x2_ctrl
// Sequencer for the 2x2 systolic matrix-multiply array: accepts an operand
// pair, clears the array, streams skewed rows/columns, waits for the drain,
// captures C and presents it over a valid/ready handshake.
// Optional feature macro: SYS2X2_PERF_CNT_EN (adds op_count output).
// Ports:
//   clk                 in  1     clock
//   rst                 in  1     asynchronous active-low reset
//   in_valid/in_ready   in/out    operand handshake (ready only in IDLE)
//   a_mat, b_mat        in  4*DW  flattened {x11,x10,x01,x00}
//   arr_rst             out 1     one-cycle active-high array clear
//   arr_a_row0/1        out DW    A edge feeds
//   arr_b_col0/1        out DW    B edge feeds
//   arr_c00..arr_c11    in  DW    array results
//   out_valid/out_ready out/in    result handshake
//   c_mat               out 4*DW  captured {c11,c10,c01,c00}
//   busy                out 1     high outside IDLE
//   op_count            out 32    completed ops (SYS2X2_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready high (except first cycle out of reset)
// ST_CLEAR | arr_rst high for one cycle, feeds zero
// ST_FEED  | three skewed feed steps presented on the edge ports
// ST_DRAIN | feeds zero, DRAIN_CYC cycles, C captured on the last one
// ST_DONE  | out_valid high until out_ready
// ---------------------------------------------------------------------------
module systolic_2x2_ctrl
   import sys2x2_pkg::*;
#(
   parameter int DW        = 32,
   parameter int DRAIN_CYC = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*DW-1:0] a_mat,
   input  logic [4*DW-1:0] b_mat,
   output logic            arr_rst,
   output logic [DW-1:0]   arr_a_row0,
   output logic [DW-1:0]   arr_a_row1,
   output logic [DW-1:0]   arr_b_col0,
   output logic [DW-1:0]   arr_b_col1,
   input  logic [DW-1:0]   arr_c00,
   input  logic [DW-1:0]   arr_c01,
   input  logic [DW-1:0]   arr_c10,
   input  logic [DW-1:0]   arr_c11,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*DW-1:0] c_mat,
   output logic            busy
`ifdef SYS2X2_PERF_CNT_EN
   ,
   output logic [31:0]     op_count
`endif
);

   localparam int DCW = drain_cnt_w(DRAIN_CYC);

   state_t          state;
   logic [1:0]      step;    // index of the next feed step to present
   logic [DCW-1:0]  dcnt;
   logic [4*DW-1:0] a_op;
   logic [4*DW-1:0] b_op;
   logic [DW-1:0]   nxt_row0, nxt_row1, nxt_col0, nxt_col1;

   sys2x2_feed_mux #(.DW(DW)) u_feed_mux (
      .step (step),
      .a_op (a_op),
      .b_op (b_op),
      .row0 (nxt_row0),
      .row1 (nxt_row1),
      .col0 (nxt_col0),
      .col1 (nxt_col1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         step       <= 2'd0;
         dcnt       <= '0;
         a_op       <= '0;
         b_op       <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         arr_rst    <= 1'b0;
         arr_a_row0 <= '0;
         arr_a_row1 <= '0;
         arr_b_col0 <= '0;
         arr_b_col1 <= '0;
         out_valid  <= 1'b0;
         c_mat      <= '0;
`ifdef SYS2X2_PERF_CNT_EN
         op_count   <= 32'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  a_op     <= a_mat;
                  b_op     <= b_mat;
                  step     <= 2'd0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  arr_rst  <= 1'b1;
                  state    <= ST_CLEAR;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ST_CLEAR: begin
               arr_rst    <= 1'b0;
               arr_a_row0 <= nxt_row0;
               arr_a_row1 <= nxt_row1;
               arr_b_col0 <= nxt_col0;
               arr_b_col1 <= nxt_col1;
               step       <= step + 2'd1;
               state      <= ST_FEED;
            end
            ST_FEED: begin
               if (step == 2'(FEED_STEPS)) begin
                  arr_a_row0 <= '0;
                  arr_a_row1 <= '0;
                  arr_b_col0 <= '0;
                  arr_b_col1 <= '0;
                  dcnt       <= DCW'(DRAIN_CYC - 1);
                  state      <= ST_DRAIN;
               end else begin
                  arr_a_row0 <= nxt_row0;
                  arr_a_row1 <= nxt_row1;
                  arr_b_col0 <= nxt_col0;
                  arr_b_col1 <= nxt_col1;
                  step       <= step + 2'd1;
               end
            end
            ST_DRAIN: begin
               if (dcnt == '0) begin
                  c_mat     <= {arr_c11, arr_c10, arr_c01, arr_c00};
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  dcnt <= dcnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
`ifdef SYS2X2_PERF_CNT_EN
                  op_count  <= op_count + 32'd1;
`endif
               end
            end
            default: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/systolic_2x2_ctrl.md
Name: systolic_2x2_ctrl

Overview:
Sequencer for the 2x2 systolic matrix-multiply array. Accepts a full operand pair (A, B, 2x2 each) over a valid/ready handshake. Clears the array accumulators, then streams skewed A rows and B columns into the array edge ports. Waits for the pipeline to drain, captures C[0..1][0..1] into output registers and presents them over a valid/ready result handshake. Sits between the operand source (DMA/buffer) and the array instance.

Parameters:
DW, 32, element width of A, B and C (matches array datapath)
DRAIN_CYC, 2, cycles after last feed before C is captured; covers PE register skew plus PE accumulate latency

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller accepts operands (high only in IDLE)
a_mat  in  4*DW  A flattened {a11,a10,a01,a00}, a00 in LSBs
b_mat  in  4*DW  B flattened {b11,b10,b01,b00}, b00 in LSBs
arr_rst  out  1  active-high clear to array rst, one cycle per op
arr_a_row0  out  DW  to array a00 (row-0 edge)
arr_a_row1  out  DW  to array a01 (row-1 edge)
arr_b_col0  out  DW  to array b00 (col-0 edge)
arr_b_col1  out  DW  to array b01 (col-1 edge)
arr_c00, arr_c01, arr_c10, arr_c11  in  DW each  array results
out_valid  out  1  result registers valid
out_ready  in  1  consumer accepts result
c_mat  out  4*DW  captured {c11,c10,c01,c00}
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=1 only after reset release; arr_rst=0; all arr_* feeds=0; out_valid=0; c_mat=0; busy=0; operand regs=0.
- States: IDLE, CLEAR, FEED, DRAIN, DONE. 2-bit step counter for FEED, counter ceil(log2(DRAIN_CYC+1)) for DRAIN.
- IDLE: in_ready=1. On in_valid: latch a_mat/b_mat, go to CLEAR. Without in_valid: stay.
- CLEAR (1 cycle): arr_rst=1, feeds=0 -> FEED step 0.
- FEED (3 cycles), feeds registered, outputs per step:
  step0: row0=a00, row1=0, col0=b00, col1=0
  step1: row0=a01, row1=a10, col0=b10, col1=b01
  step2: row0=0, row1=a11, col0=0, col1=b11
  -> DRAIN.
- DRAIN: feeds=0 for DRAIN_CYC cycles. On the last cycle, capture arr_c* into c_mat -> DONE.
- DONE: out_valid=1, c_mat stable. On out_ready: out_valid falls next cycle -> IDLE. Without out_ready: hold indefinitely, array untouched.
- Latency: handshake at cycle 0; out_valid high at cycle 5+DRAIN_CYC (7 default).
- Throughput: one op per 6+DRAIN_CYC cycles with out_ready held high.
- in_valid while busy: ignored; operands not sampled; in_ready=0.
- out_ready outside DONE: ignored.
- Controller does no arithmetic. C wrap-around modulo 2^DW is the array's behaviour; c_mat passes bits unchanged.
- Reset mid-operation: immediate return to IDLE with reset values. Partially streamed data is discarded. The next op's CLEAR guarantees clean accumulators.

Optional Feature:
SYS2X2_PERF_CNT_EN: adds output op_count (32 bits). It increments on each DONE->IDLE transfer, wraps at 2^32 to 0, and resets to 0. Without the macro the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package sys2x2_pkg holds:
  - state enum typedef
  - FEED_STEPS=3 constant
  - element-slice index constants for the flattened matrices
- One sub-module, sys2x2_feed_mux: combinational step->edge-value selection. The FSM and output registers stay in systolic_2x2_ctrl.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 -> out_valid at cycle 7, c_mat={50,43,22,19}.
- A=identity, B=[[9,8],[7,6]] -> C=[[9,8],[7,6]]; check the arr_rst pulse is exactly 1 cycle and the feed sequence matches steps 0-2.
- Hold out_ready=0 for 10 cycles after out_valid; pulse in_valid throughout -> c_mat stable, in_ready=0, no new op until out_ready accepted.
- Assert rst low during FEED step1 -> all outputs zero immediately. Then run the first vector -> correct {50,43,22,19} with no residue.
- Two back-to-back ops, in_valid held, out_ready=1 -> second accepted the cycle after DONE->IDLE, results correct. With SYS2X2_PERF_CNT_EN, op_count=2.
